// File: rtl/decrypt_iter.sv
// Iterative DES decryption core: one Feistel round per clock (two with DECRYPT_UNROLL2_EN),
// subkeys taken K16 first, four-phase req/ack handshake, registered outputs.
module decrypt_iter #(
  parameter int unsigned N_K = 64,
  parameter int unsigned N_B = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] c,
  output logic           ack,
  output logic           busy,
  output logic [N_B-1:0] m
);

`ifdef DECRYPT_UNROLL2_EN
  localparam int unsigned RoundsPerCyc = 2;
  localparam int unsigned CntW         = 4;
  localparam int unsigned LastCnt      = 7;
`else
  localparam int unsigned RoundsPerCyc = 1;
  localparam int unsigned CntW         = 5;
  localparam int unsigned LastCnt      = 15;
`endif

  localparam int unsigned IpTab [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FpTab [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned ETab [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned PTab [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  // S1..S8, each 4 rows x 16 columns
  localparam int unsigned SBox [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  // Tables number bits from 1 at the MSB.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-IpTab[i]];
    return o;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = x[64-FpTab[i]];
    return o;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = x[64-Pc1Tab[i]];
    return o;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[56-Pc2Tab[i]];
    return o;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = x[32-ETab[i]];
    return o;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = x[32-PTab[i]];
    return o;
  endfunction

  function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] sk);
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;
    x = perm_e(r) ^ sk;
    s = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(SBox[64*b + 32*32'(six[5]) + 16*32'(six[0]) + 32'(six[4:1])]);
    end
    return perm_p(s);
  endfunction

  // Right-rotation applied before decryption round rnd+1 (K16 needs none).
  function automatic logic [1:0] rot_amt(input logic [4:0] rnd);
    if (rnd == 5'd0) return 2'd0;
    if (rnd == 5'd1 || rnd == 5'd8 || rnd == 5'd15) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       l_q, l_d, r_q, r_d;
  logic [27:0]       c_q, c_d, d_q, d_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ack_q, ack_d, busy_q, busy_d;
  logic [N_B-1:0]    m_q, m_d;
  logic [31:0]       l_t, r_t, f_t;
  logic [27:0]       c_t, d_t;
  logic [4:0]        rnd;

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    m_d     = m_q;
    l_t     = l_q;
    r_t     = r_q;
    c_t     = c_q;
    d_t     = d_q;
    f_t     = '0;
    rnd     = '0;
    for (int unsigned j = 0; j < RoundsPerCyc; j++) begin
      rnd = 5'(RoundsPerCyc * 32'(cnt_q) + j);
      c_t = rotr28(c_t, rot_amt(rnd));
      d_t = rotr28(d_t, rot_amt(rnd));
      f_t = r_t;
      r_t = l_t ^ f_round(r_t, perm_pc2({c_t, d_t}));
      l_t = f_t;
    end
    case (state_q)
      StIdle: begin
        if (req) begin
          {l_d, r_d} = perm_ip(c);
          {c_d, d_d} = perm_pc1(k);
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StRound;
        end
      end
      StRound: begin
        l_d = l_t;
        r_d = r_t;
        c_d = c_t;
        d_d = d_t;
        if (cnt_q == CntW'(LastCnt)) begin
          m_d     = perm_fp({r_t, l_t});
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      m_q     <= m_d;
    end
  end

  assign ack  = ack_q;
  assign busy = busy_q;
  assign m    = m_q;

endmodule

// File: tb/tb_decrypt_iter.sv
// Directed bench for decrypt_iter: known-answer vectors through a scoreboard queue,
// handshake corners and asynchronous reset; honours DECRYPT_UNROLL2_EN for latency.
module tb_decrypt_iter;

`ifdef DECRYPT_UNROLL2_EN
  localparam int Lat = 8;
`else
  localparam int Lat = 16;
`endif

  localparam logic [63:0] KatK = 64'h133457799BBCDFF1;
  localparam logic [63:0] KatC = 64'h85E813540F0AB405;
  localparam logic [63:0] KatM = 64'h0123456789ABCDEF;

  logic        clk;
  logic        rst;
  logic        req;
  logic [63:0] k;
  logic [63:0] c;
  logic        ack;
  logic        busy;
  logic [63:0] m;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];

  decrypt_iter dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .k    (k),
    .c    (c),
    .ack  (ack),
    .busy (busy),
    .m    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, wait for ack within a bound, compare against the scoreboard head.
  task automatic run(input string tag, input logic [63:0] kk, input logic [63:0] cc,
                     input logic [63:0] exp_m, input bit pulse, input bit scramble);
    int lat;
    logic [63:0] exp;
    k   = kk;
    c   = cc;
    req = 1'b1;
    sb_q.push_back(exp_m);
    lat = 0;
    step();
    lat++;
    check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    if (pulse) req = 1'b0;
    while (!ack && lat < 60) begin
      if (scramble) begin
        k = {$urandom, $urandom};
        c = {$urandom, $urandom};
      end
      step();
      lat++;
    end
    check({tag, "_ack"}, 64'(ack), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(Lat + 1));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : ~m;
    check({tag, "_m"}, m, exp);
  endtask

  initial begin
    rst = 1'b0;
    req = 1'b1;
    k   = {$urandom, $urandom};
    c   = {$urandom, $urandom};

    // Reset held with arbitrary inputs, then released.
    step();
    step();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m", m, 64'd0);
    req = 1'b0;
    #2;
    rst = 1'b1;
    step();
    check("rel_ack", 64'(ack), 64'd0);
    check("rel_busy", 64'(busy), 64'd0);
    check("rel_m", m, 64'd0);

    // Known answer with operands changing after the load edge; req held high afterwards.
    run("kat", KatK, KatC, KatM, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("held_ack", 64'(ack), 64'd1);
      check("held_busy", 64'(busy), 64'd0);
      check("held_m", m, KatM);
    end
    req = 1'b0;
    step();
    check("kat_drop_ack", 64'(ack), 64'd0);

    // Zero key, then an immediate second request.
    run("zero", 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000,
        1'b0, 1'b0);
    req = 1'b0;
    step();
    check("zero_drop_ack", 64'(ack), 64'd0);
    run("second", 64'h0101010101010101, 64'h8000000000000000, 64'h95F8A5E5DD31D900,
        1'b0, 1'b0);
    req = 1'b0;
    step();

    // One-cycle req pulse: ack exactly one cycle, no restart.
    run("pulse", KatK, KatC, KatM, 1'b1, 1'b0);
    step();
    check("pulse_ack_width", 64'(ack), 64'd0);
    step();
    step();
    check("pulse_no_restart", 64'(busy), 64'd0);

    // Reset at E8 of a run clears outputs without a clock edge.
    k   = KatK;
    c   = KatC;
    req = 1'b1;
    sb_q.push_back(KatM);
    for (int i = 0; i < 8; i++) step();
    check("mid_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_ack", 64'(ack), 64'd0);
    check("mid_m", m, 64'd0);
    void'(sb_q.pop_front());
    req = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    step();
    run("after_rst", KatK, KatC, KatM, 1'b0, 1'b0);
    req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
